// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder/full-subtractor cell plus a carry/borrow
// flop, consuming one operand bit per clock LSB first under a start/done handshake.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             cb;
  logic             mode_q;

  logic             sum_bit;
  logic             cb_next;
  logic             last_bit;
  logic [WIDTH-1:0] shifted;

  // Shared bit cell: sum and difference bits are identical, only the carry/borrow differs.
  always_comb begin
    sum_bit  = sa[0] ^ sb[0] ^ cb;
    cb_next  = 1'b0;
    if (mode_q) begin
      cb_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & cb);
    end else begin
      cb_next = (sa[0] & sb[0]) | ((sa[0] ^ sb[0]) & cb);
    end
    shifted  = {sum_bit, sr[WIDTH-1:1]};
    last_bit = (cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result outputs are written only on the MSB edge so they hold across later operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      cnt      <= '0;
      cb       <= 1'b0;
      mode_q   <= 1'b0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            mode_q <= mode;
            cb     <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= shifted;
          cb  <= cb_next;
          cnt <= cnt + CW'(1);
          if (last_bit) begin
            result   <= shifted;
            c_out    <= cb_next;
            overflow <= cb ^ cb_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: an 8-bit instance for directed, handshake and
// reset scenarios, and a 4-bit instance checked exhaustively against a behavioural model.
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0, mode8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, c_out8, overflow8;
  logic [7:0] result8;

  logic       start4 = 1'b0, mode4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, c_out4, overflow4;
  logic [3:0] result4;

  int assert_count = 0;
  int fail_count   = 0;

  logic [9:0] q8[$];
  logic [5:0] q4[$];
  logic [9:0] last_exp = '0;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .c_out(c_out8), .overflow(overflow8)
  );

  serial_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .c_out(c_out4), .overflow(overflow4)
  );

  always #5 clk = ~clk;

  // Returns {overflow, carry/borrow, result} for a w-bit operation.
  function automatic logic [33:0] model(input int w, input logic m,
                                        input logic [31:0] x, input logic [31:0] y);
    logic [32:0] full;
    logic [31:0] mask, res;
    logic        c, v, sx, sy, sres;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    x = x & mask;
    y = y & mask;
    if (!m) begin
      full = {1'b0, x} + {1'b0, y};
      c    = full[w];
    end else begin
      full = {1'b0, x} - {1'b0, y};
      c    = (x < y);
    end
    res  = full[31:0] & mask;
    sx   = x[w-1];
    sy   = y[w-1];
    sres = res[w-1];
    v    = m ? ((sx != sy) && (sres != sx)) : ((sx == sy) && (sres != sx));
    return {v, c, res};
  endfunction

  function automatic logic [9:0] exp8(input logic m, input logic [7:0] x, input logic [7:0] y);
    logic [33:0] r;
    r = model(8, m, {24'h0, x}, {24'h0, y});
    return {r[33], r[32], r[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one 8-bit request at a falling edge, scrambles operands after acceptance.
  task automatic applyStimulus(input logic m, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start8 = 1'b1;
    mode8  = m;
    a8     = x;
    b8     = y;
    @(posedge clk);
    q8.push_back(exp8(m, x, y));
    #1;
    start8 = 1'b0;
    mode8  = ~m;
    a8     = ~x;
    b8     = y ^ 8'h5A;
  endtask

  task automatic checkOutput(input string tag);
    int         busy_cycles;
    bit         seen;
    logic [9:0] exp;
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
      else if (busy8) busy_cycles++;
    end
    if (!seen || q8.size() == 0) begin
      assert_count++;
      fail_count++;
      $error("FAIL %s_timeout observed=done_missing expected=done_pulse", tag);
      q8.delete();
      return;
    end
    exp = q8.pop_front();
    check({tag, "_result"},   {24'h0, result8}, {24'h0, exp[7:0]});
    check({tag, "_c_out"},    {31'h0, c_out8},    {31'h0, exp[8]});
    check({tag, "_overflow"}, {31'h0, overflow8}, {31'h0, exp[9]});
    check({tag, "_busy_len"}, busy_cycles, 32'd8);
    check({tag, "_busy_at_done"}, {31'h0, busy8}, 32'h0);
    last_exp = exp;
    @(negedge clk);
    check({tag, "_done_single"}, {31'h0, done8}, 32'h0);
  endtask

  initial begin
    logic [33:0] r4;
    logic [7:0]  ha, hb;
    logic        hm;
    bit          seen;

    // Reset state
    #3;
    check("rst_busy",     {31'h0, busy8},     32'h0);
    check("rst_done",     {31'h0, done8},     32'h0);
    check("rst_result",   {24'h0, result8},   32'h0);
    check("rst_c_out",    {31'h0, c_out8},    32'h0);
    check("rst_overflow", {31'h0, overflow8}, 32'h0);
    #10;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {31'h0, busy8}, 32'h0);
    check("post_rst_done", {31'h0, done8}, 32'h0);

    // Directed operations
    applyStimulus(1'b0, 8'h3C, 8'h45); checkOutput("add_3c_45");
    applyStimulus(1'b0, 8'hFF, 8'h01); checkOutput("add_ff_01");
    applyStimulus(1'b1, 8'h10, 8'h20); checkOutput("sub_10_20");
    applyStimulus(1'b1, 8'h80, 8'h01); checkOutput("sub_80_01");
    applyStimulus(1'b1, 8'h55, 8'h55); checkOutput("sub_55_55");
    applyStimulus(1'b0, 8'h7F, 8'h01); checkOutput("add_7f_01");

    // start held high with operands changing every cycle: accepts every 10 cycles
    $display("[TB] held-start handshake phase");
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (j % 10 == 9) begin
        check("held_done", {31'h0, done8}, 32'h1);
        if (q8.size() != 0) begin
          last_exp = q8.pop_front();
          check("held_result", {22'h0, overflow8, c_out8, result8}, {22'h0, last_exp});
        end
      end else begin
        check("held_done_low", {31'h0, done8}, 32'h0);
      end
      if (j % 10 >= 1 && j % 10 <= 8) begin
        check("held_busy", {31'h0, busy8}, 32'h1);
        check("held_outputs_hold", {22'h0, overflow8, c_out8, result8}, {22'h0, last_exp});
      end else begin
        check("held_busy_low", {31'h0, busy8}, 32'h0);
      end
      ha = 8'((j * 37 + 5) & 255);
      hb = 8'((j * 91 + 200) & 255);
      hm = (j % 3 == 1);
      start8 = 1'b1;
      a8     = ha;
      b8     = hb;
      mode8  = hm;
      @(posedge clk);
      if (j % 10 == 0) q8.push_back(exp8(hm, ha, hb));
    end
    @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    q8.delete();

    // Reset in the middle of an operation
    $display("[TB] mid-run reset phase");
    applyStimulus(1'b0, 8'hA5, 8'h3C);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",     {31'h0, busy8},     32'h0);
    check("midrst_done",     {31'h0, done8},     32'h0);
    check("midrst_result",   {24'h0, result8},   32'h0);
    check("midrst_c_out",    {31'h0, c_out8},    32'h0);
    check("midrst_overflow", {31'h0, overflow8}, 32'h0);
    q8.delete();
    repeat (3) begin
      @(negedge clk);
      check("midrst_hold_done", {31'h0, done8}, 32'h0);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1'b1;
    end
    check("aborted_no_done", {31'h0, seen}, 32'h0);
    last_exp = '0;
    applyStimulus(1'b0, 8'hA5, 8'h3C); checkOutput("after_rst_add");
    applyStimulus(1'b1, 8'h01, 8'h02); checkOutput("after_rst_sub");

    // Exhaustive 4-bit sweep
    $display("[TB] exhaustive WIDTH=4 phase");
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          @(negedge clk);
          start4 = 1'b1;
          mode4  = m[0];
          a4     = 4'(x);
          b4     = 4'(y);
          @(posedge clk);
          r4 = model(4, m[0], 32'(x), 32'(y));
          q4.push_back({r4[33], r4[32], r4[3:0]});
          #1;
          start4 = 1'b0;
          a4     = ~a4;
          seen   = 1'b0;
          for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (done4) seen = 1'b1;
          end
          if (!seen || q4.size() == 0) begin
            assert_count++;
            fail_count++;
            $error("FAIL w4_timeout observed=done_missing expected=done_pulse m=%0d a=%0d b=%0d", m, x, y);
            q4.delete();
          end else begin
            check($sformatf("w4_m%0d_a%0d_b%0d", m, x, y),
                  {26'h0, overflow4, c_out4, result4}, {26'h0, q4.pop_front()});
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
